sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
Scan controller for the 4-digit seven-segment display driver.
- Generates the time-multiplexed digit_sel sequence from a refresh prescaler.
- Holds the displayed value (data, hex_dec, sign) in display registers. Their outputs feed the display driver directly.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so a refresh frame never mixes two values.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit period (≥2); 1 kHz digit rate at 100 MHz.
- BLANK_CYCLES, 8, anti-ghost blank length at the start of each digit period (1 ≤ BLANK_CYCLES < REFRESH_DIV); used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  scan enable; 0 freezes the scan
- load_valid  in  1  producer has a new display value
- load_ready  out  1  pending slot empty; can accept
- load_data  in  16  new value (hex nibbles or binary for BCD)
- load_hex_dec  in  1  new mode: 1 = hex, 0 = decimal
- load_sign  in  1  new sign flag
- digit_sel  out  2  current digit index to the display driver
- disp_data  out  16  committed value
- disp_hex_dec  out  1  committed mode
- disp_sign  out  1  committed sign
- digit_tick  out  1  one-cycle pulse on each digit advance
- frame_done  out  1  one-cycle pulse on a 3→0 wrap
- blank  out  1  force all anodes off (optional feature; else tied 0)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - digit_sel=0, disp_data=0, disp_hex_dec=0, disp_sign=0, digit_tick=0, frame_done=0, blank=0, load_ready=1.
  - Prescaler cleared; pending slot emptied, so a pending value is dropped.
  - State=IDLE.
  - A reset mid-frame or mid-handshake takes priority over everything.
- FSM states are IDLE and SCAN.
  - IDLE→SCAN when en=1. SCAN→IDLE when en=0.
  - In IDLE the prescaler, digit_sel and display registers hold; handshake accepts still work.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 in SCAN; width is $clog2(REFRESH_DIV).
  - A tick occurs at count==REFRESH_DIV-1; the counter wraps to 0.
- On a tick:
  - digit_sel ← digit_sel+1 mod 4.
  - digit_tick=1 in the next cycle, aligned with the new digit_sel.
- Frame boundary (tick while digit_sel==3):
  - digit_sel→0 and frame_done=1 in the same cycle as digit_tick.
  - If the pending slot is full, disp_* ← pending and the slot is cleared in the same edge. The new value is visible together with digit_sel=0.
- Handshake:
  - load_ready = slot empty (registered).
  - Accept occurs on load_valid & load_ready; the slot becomes full and load_ready=0 from the next cycle.
  - load_valid with load_ready=0 is held by the producer; the controller ignores it.
- Simultaneous accept and frame boundary: no bypass. The value enters the slot and commits at the next frame boundary.
- Commit only occurs in SCAN. In IDLE a full slot waits.
- Steady-state latency from accept to display is at most 4·REFRESH_DIV+1 cycles.

Optional Feature:
Macro SSEG_GHOST_BLANK_EN.
- Defined: blank=1 from the edge that advances digit_sel through prescaler count BLANK_CYCLES-1, then blank=0 for the rest of the digit period. blank=0 in IDLE.
- Undefined: blank is tied to constant 0, no blank logic is synthesized, and BLANK_CYCLES is ignored.

Decomposition:
- Package sseg_pkg:
  - NUM_DIGITS=4.
  - typedef digit_sel_t (logic [1:0]).
  - typedef scan_state_t enum {IDLE, SCAN}.
  - typedef disp_word_t struct {data[15:0], hex_dec, sign}, used for both the pending slot and the display registers.
- Sub-module refresh_prescaler: parameter DIV, inputs clk/rst_n/run, output tick. Instantiated once.

Test Plan:
All scenarios use REFRESH_DIV=4 and BLANK_CYCLES=2.
1. Reset then en=1 → digit_sel steps 0,1,2,3,0 every 4 cycles; digit_tick pulses every 4 cycles; frame_done pulses only on the 3→0 wrap; disp_data=0.
2. Load 0x1234 with hex_dec=1 while digit_sel=1 → load_ready drops the next cycle. disp_data stays 0 until the 3→0 wrap, then becomes 0x1234 with digit_sel=0; load_ready returns to 1.
3. Load 0x00AA, then present load_valid with 0x5555 before the frame boundary → 0x5555 is not accepted. At the wrap, disp_data=0x00AA; 0x5555 is accepted next cycle and displayed at the following wrap.
4. Drop en for 10 cycles while digit_sel=2 → digit_sel, the prescaler and disp_* hold. After en=1 the scan resumes with the same count, without skipping or repeating a tick.
5. Load 0x0FFF with load_valid asserted in the same cycle as a frame boundary → accepted into the slot; disp_data is unchanged at that wrap and becomes 0x0FFF at the next wrap.
6. Assert rst_n=0 with the slot full and digit_sel=3 → the next edge gives digit_sel=0, disp_data=0 and load_ready=1, and the pending value is never displayed. With SSEG_GHOST_BLANK_EN defined, blank=1 for exactly 2 cycles after each digit_tick.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types for the seven-segment scan controller.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_sel_t;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        hex_dec;
    logic        sign;
  } disp_word_t;

endpackage

// File: rtl/sseg_refresh_prescaler.sv
// Digit-period prescaler: counts 0..DIV-1 while run is high and
// flags the last count with a combinational tick.
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = run && (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      if (tick) cnt_d = '0;
      else      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// 4-digit display scan controller with frame-aligned value commit.
// Optional anti-ghost blanking is built when SSEG_GHOST_BLANK_EN is defined.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic        load_hex_dec,
  input  logic        load_sign,
  output logic [1:0]  digit_sel,
  output logic [15:0] disp_data,
  output logic        disp_hex_dec,
  output logic        disp_sign,
  output logic        digit_tick,
  output logic        frame_done,
  output logic        blank
);

  scan_state_t state_q, state_d;
  digit_sel_t  sel_q, sel_d;
  disp_word_t  disp_q, disp_d;
  disp_word_t  slot_q, slot_d;
  logic        full_q, full_d;
  logic        ready_q, ready_d;
  logic        dtick_q, dtick_d;
  logic        fdone_q, fdone_d;

  logic run;
  logic tick;
  logic accept;
  logic wrap;
  logic commit;

  assign run = (state_q == SCAN) && en;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  // Accept and commit are exclusive: accept needs an empty slot.
  always_comb begin
    accept  = load_valid && ready_q;
    wrap    = tick && (sel_q == digit_sel_t'(NUM_DIGITS - 1));
    commit  = wrap && full_q;
    state_d = en ? SCAN : IDLE;
    sel_d   = tick ? sel_q + digit_sel_t'(1) : sel_q;
    dtick_d = tick;
    fdone_d = wrap;
    disp_d  = commit ? slot_q : disp_q;
    slot_d  = slot_q;
    full_d  = full_q;
    if (commit) full_d = 1'b0;
    if (accept) begin
      full_d         = 1'b1;
      slot_d.data    = load_data;
      slot_d.hex_dec = load_hex_dec;
      slot_d.sign    = load_sign;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      disp_q  <= '0;
      slot_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      dtick_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
      slot_q  <= slot_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      dtick_q <= dtick_d;
      fdone_q <= fdone_d;
    end
  end

  assign load_ready   = ready_q;
  assign digit_sel    = sel_q;
  assign disp_data    = disp_q.data;
  assign disp_hex_dec = disp_q.hex_dec;
  assign disp_sign    = disp_q.sign;
  assign digit_tick   = dtick_q;
  assign frame_done   = fdone_q;

`ifdef SSEG_GHOST_BLANK_EN
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blank_q, blank_d;

  // Remaining blank cycles in this digit period; frozen with the scan.
  always_comb begin
    bcnt_d = bcnt_q;
    if (tick) begin
      bcnt_d = BW'(BLANK_CYCLES);
    end else if (run && (bcnt_q != '0)) begin
      bcnt_d = bcnt_q - BW'(1);
    end
    blank_d = (state_d == SCAN) && (bcnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = |BLANK_CYCLES;
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized and directed bench for sseg_scan_ctrl against a
// frame-level reference model.
module tb_sseg_scan_ctrl;

  localparam int DIV = 4;
  localparam int BLK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_hex_dec;
  logic        load_sign;
  logic [1:0]  digit_sel;
  logic [15:0] disp_data;
  logic        disp_hex_dec;
  logic        disp_sign;
  logic        digit_tick;
  logic        frame_done;
  logic        blank;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_hex_dec (load_hex_dec),
    .load_sign    (load_sign),
    .digit_sel    (digit_sel),
    .disp_data    (disp_data),
    .disp_hex_dec (disp_hex_dec),
    .disp_sign    (disp_sign),
    .digit_tick   (digit_tick),
    .frame_done   (frame_done),
    .blank        (blank)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: scan progress is a count of scanning cycles; digit and
  // prescaler position follow from it arithmetically.
  int          m_n;
  bit          m_scan;
  bit          m_seen;
  bit          m_dt;
  bit          m_fd;
  bit          m_acc;
  logic [17:0] m_disp;
  logic [17:0] m_q[$];

  task automatic model();
    bit run;
    if (!rst_n) begin
      m_n = 0; m_scan = 0; m_seen = 0;
      m_dt = 0; m_fd = 0; m_acc = 0;
      m_disp = '0;
      m_q.delete();
    end else begin
      run   = m_scan && en;
      m_acc = load_valid && (m_q.size() == 0);
      m_dt  = run && (m_n % DIV == DIV - 1);
      m_fd  = m_dt && ((m_n / DIV) % 4 == 3);
      if (run) m_n++;
      if (m_dt) m_seen = 1;
      if (m_fd && m_q.size() != 0) m_disp = m_q.pop_front();
      if (m_acc) m_q.push_back({load_data, load_hex_dec, load_sign});
      m_scan = en;
    end
  endtask

  function automatic int m_sel();
    return (m_n / DIV) % 4;
  endfunction

  task automatic cyc();
    bit exp_blank;
    @(posedge clk);
    model();
    #1;
`ifdef SSEG_GHOST_BLANK_EN
    exp_blank = m_scan && m_seen && ((m_n % DIV) < BLK);
`else
    exp_blank = 0;
`endif
    chk("sel",   32'(digit_sel),    32'(m_sel()));
    chk("data",  32'(disp_data),    32'(m_disp[17:2]));
    chk("hex",   32'(disp_hex_dec), 32'(m_disp[1]));
    chk("sign",  32'(disp_sign),    32'(m_disp[0]));
    chk("dtick", 32'(digit_tick),   32'(m_dt));
    chk("fdone", 32'(frame_done),   32'(m_fd));
    chk("ready", 32'(load_ready),   32'(m_q.size() == 0));
    chk("blank", 32'(blank),        32'(exp_blank));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [15:0] d, input logic h,
                      input logic s);
    int t;
    load_valid = 1; load_data = d; load_hex_dec = h; load_sign = s;
    t = 0;
    do begin
      cyc();
      t++;
    end while (!m_acc && t < 200);
    if (!m_acc) chk("send_timeout", 0, 1);
    load_valid = 0;
  endtask

  task automatic wait_fd();
    int t;
    t = 0;
    do begin
      cyc();
      t++;
    end while (!m_fd && t < 200);
    if (!m_fd) chk("frame_timeout", 0, 1);
  endtask

  task automatic wait_sel(input int s);
    int t;
    t = 0;
    while (m_sel() != s && t < 200) begin
      cyc();
      t++;
    end
    if (m_sel() != s) chk("sel_timeout", 0, 1);
  endtask

  initial begin
    int t;
    rst_n = 0; en = 0; load_valid = 0;
    load_data = '0; load_hex_dec = 0; load_sign = 0;
    run_n(2);
    chk("rst_sel",   32'(digit_sel),  0);
    chk("rst_ready", 32'(load_ready), 1);
    rst_n = 1; en = 1;
    run_n(40);

    wait_sel(1);
    send(16'h1234, 1, 0);
    chk("s2_ready_low", 32'(load_ready), 0);
    chk("s2_hold", 32'(disp_data), 0);
    wait_fd();
    chk("s2_data", 32'(disp_data), 32'h1234);
    chk("s2_sel0", 32'(digit_sel), 0);
    run_n(20);

    send(16'h00AA, 0, 1);
    send(16'h5555, 1, 1);
    chk("s3_first", 32'(disp_data), 32'h00AA);
    wait_fd();
    chk("s3_second", 32'(disp_data), 32'h5555);

    wait_sel(2);
    en = 0;
    run_n(10);
    en = 1;
    run_n(30);

    t = 0;
    while (!(m_scan && (m_n % (4 * DIV)) == 4 * DIV - 1) && t < 200) begin
      cyc();
      t++;
    end
    load_valid = 1; load_data = 16'h0FFF;
    load_hex_dec = 1; load_sign = 0;
    cyc();
    load_valid = 0;
    chk("s5_fd", 32'(frame_done), 1);
    chk("s5_acc", 32'(load_ready), 0);
    chk("s5_hold", 32'(disp_data), 32'h5555);
    wait_fd();
    chk("s5_data", 32'(disp_data), 32'h0FFF);

    send(16'hBEEF, 1, 1);
    wait_sel(3);
    rst_n = 0;
    cyc();
    chk("s6_sel",   32'(digit_sel),  0);
    chk("s6_data",  32'(disp_data),  0);
    chk("s6_ready", 32'(load_ready), 1);
    rst_n = 1;
    run_n(40);
    chk("s6_drop", 32'(disp_data), 0);

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 15) != 0);
      if (!load_valid || m_acc) begin
        load_valid   = ($urandom_range(0, 3) == 0);
        load_data    = 16'($urandom);
        load_hex_dec = 1'($urandom);
        load_sign    = 1'($urandom);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
